// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
// morse_pkg -- shared state encoding, timing constants and letter lookup
// Revision: 1.0
// ============================================================================
package morse_pkg;

  localparam int LETTER_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_MARK    = 3'd2,
    ST_GAP_SYM = 3'd3,
    ST_GAP_LTR = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam logic [1:0] DOT_UNITS     = 2'd1;
  localparam logic [1:0] DASH_UNITS    = 2'd3;
  localparam logic [1:0] SYM_GAP_UNITS = 2'd1;
  localparam logic [1:0] LTR_GAP_UNITS = 2'd3;

  // Pattern is MSB-first (bit 3 = first element), 1 = dash.
  typedef struct packed {
    logic [2:0] len;
    logic [3:0] pattern;
  } letter_t;

  function automatic letter_t letter_lookup(input logic [LETTER_W-1:0] code);
    letter_t l;
    case (code)
      3'd0:    l = '{len: 3'd2, pattern: 4'b0100};  // A .-
      3'd1:    l = '{len: 3'd4, pattern: 4'b1000};  // B -...
      3'd2:    l = '{len: 3'd4, pattern: 4'b1010};  // C -.-.
      3'd3:    l = '{len: 3'd3, pattern: 4'b1000};  // D -..
      3'd4:    l = '{len: 3'd1, pattern: 4'b0000};  // E .
      3'd5:    l = '{len: 3'd4, pattern: 4'b0010};  // F ..-.
      3'd6:    l = '{len: 3'd3, pattern: 4'b1100};  // G --.
      default: l = '{len: 3'd4, pattern: 4'b0000};  // H ....
    endcase
    return l;
  endfunction

  // Unit counter counts down to zero, so load it with units-1.
  function automatic logic [1:0] elem_units(input logic is_dash);
    return is_dash ? (DASH_UNITS - 2'd1) : (DOT_UNITS - 2'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/morse_letter_fifo.sv
`default_nettype none
// ============================================================================
// morse_letter_fifo -- DEPTH x 3 letter queue, sync push/pop/flush
// Revision: 1.0
// ============================================================================
module morse_letter_fifo
  import morse_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [LETTER_W-1:0] data_i,
  output logic [LETTER_W-1:0] data_o,
  output logic                full_o,
  output logic                empty_o
);

  localparam int c_AW = $clog2(DEPTH);

  logic [c_AW:0]         wr_q;
  logic [c_AW:0]         rd_q;
  logic [LETTER_W-1:0]   mem_q [DEPTH];
  logic                  w_pop;
  logic                  w_push;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[c_AW] != rd_q[c_AW]) && (wr_q[c_AW-1:0] == rd_q[c_AW-1:0]);
  assign w_pop   = pop_i && !empty_o;
  // A simultaneous pop frees the slot the push would otherwise be denied.
  assign w_push  = push_i && (!full_o || w_pop);
  assign data_o  = mem_q[rd_q[c_AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (w_push) wr_q <= wr_q + 1'b1;
      if (w_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) mem_q[wr_q[c_AW-1:0]] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/morse_msg_scheduler.sv
`default_nettype none
// ============================================================================
// morse_msg_scheduler -- queues Morse letters A..H and plays them on one LED
// Revision: 1.0
// ============================================================================
module morse_msg_scheduler
  import morse_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  parameter int DEPTH    = 8
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic [LETTER_W-1:0] letter_in,
  input  logic                push,
  input  logic                start,
  input  logic                abort,
  output logic                led,
  output logic                busy,
  output logic                done,
  output logic                fifo_full,
  output logic                fifo_empty,
  output logic                overflow
);

  localparam int                 c_DIV_W   = $clog2(TICK_DIV);
  localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(TICK_DIV - 1);

  state_e               state_q;
  logic [c_DIV_W-1:0]   div_q;
  logic [1:0]           unit_q;
  logic [2:0]           elem_q;
  logic [3:0]           pat_q;
  logic                 overflow_q;

  logic                 w_tick;
  logic                 w_pop;
  logic                 w_drop;
  logic [LETTER_W-1:0]  w_head;
  letter_t              w_lut;

  morse_letter_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLOCK_50),
    .rst_i   (RESET),
    .flush_i (abort),
    .push_i  (push && !abort),
    .pop_i   (w_pop),
    .data_i  (letter_in),
    .data_o  (w_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign w_tick = (div_q == c_DIV_MAX);
  assign w_pop  = (state_q == ST_LOAD) && !abort;
  assign w_drop = push && !abort && fifo_full && !w_pop;
  assign w_lut  = letter_lookup(w_head);

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      unit_q     <= '0;
      elem_q     <= '0;
      pat_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (w_drop)     overflow_q <= 1'b1;
      else if (start) overflow_q <= 1'b0;

      if (abort) begin
        state_q <= ST_IDLE;
        div_q   <= '0;
      end else begin
        // Every timed-state change happens on a tick, so the wrap doubles as the entry clear.
        div_q <= w_tick ? '0 : div_q + 1'b1;
        case (state_q)
          ST_IDLE: begin
            div_q <= '0;
            if (start && !fifo_empty) state_q <= ST_LOAD;
          end
          ST_LOAD: begin
            div_q   <= '0;
            pat_q   <= w_lut.pattern;
            elem_q  <= w_lut.len;
            unit_q  <= elem_units(w_lut.pattern[3]);
            state_q <= ST_MARK;
          end
          ST_MARK: begin
            if (w_tick) begin
              if (unit_q != 2'd0) begin
                unit_q <= unit_q - 2'd1;
              end else if (elem_q > 3'd1) begin
                unit_q  <= SYM_GAP_UNITS - 2'd1;
                state_q <= ST_GAP_SYM;
              end else if (fifo_empty && !push) begin
                // A push landing in this very cycle still counts as a queued letter.
                state_q <= ST_DONE;
              end else begin
                unit_q  <= LTR_GAP_UNITS - 2'd1;
                state_q <= ST_GAP_LTR;
              end
            end
          end
          ST_GAP_SYM: begin
            if (w_tick) begin
              if (unit_q != 2'd0) begin
                unit_q <= unit_q - 2'd1;
              end else begin
                pat_q   <= {pat_q[2:0], 1'b0};
                elem_q  <= elem_q - 3'd1;
                unit_q  <= elem_units(pat_q[2]);
                state_q <= ST_MARK;
              end
            end
          end
          ST_GAP_LTR: begin
            if (w_tick) begin
              if (unit_q != 2'd0) unit_q  <= unit_q - 2'd1;
              else                state_q <= ST_LOAD;
            end
          end
          ST_DONE: begin
            div_q   <= '0;
            state_q <= ST_IDLE;
          end
          default: begin
            div_q   <= '0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign led      = (state_q == ST_MARK);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_morse_msg_scheduler.sv
`default_nettype none
// ============================================================================
// tb_morse_msg_scheduler -- directed self-checking bench, TICK_DIV=4, DEPTH=8
// Revision: 1.0
// ============================================================================
module tb_morse_msg_scheduler;

  localparam int TICK_DIV = 4;
  localparam int DEPTH    = 8;

  logic       CLOCK_50 = 1'b0;
  logic       RESET    = 1'b1;
  logic [2:0] letter_in = 3'd0;
  logic       push  = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       led, busy, done, fifo_full, fifo_empty, overflow;

  int n_checks = 0;
  int n_pass   = 0;

  int led_tr[$];
  int runs[$];
  int exp_runs[$];
  int n_done;
  int done_at;

  morse_msg_scheduler #(
    .TICK_DIV (TICK_DIV),
    .DEPTH    (DEPTH)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET      (RESET),
    .letter_in  (letter_in),
    .push       (push),
    .start      (start),
    .abort      (abort),
    .led        (led),
    .busy       (busy),
    .done       (done),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .overflow   (overflow)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic push_letter(input logic [2:0] code);
    letter_in = code;
    push = 1'b1;
    step();
    push = 1'b0;
  endtask

  // Returns one cycle after start was sampled, i.e. in the LOAD cycle.
  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Records led each cycle while busy; cycle numbers are relative to the first recorded cycle.
  task automatic capture(input int first_cycle);
    int cnt;
    cnt = 0;
    led_tr.delete();
    n_done  = 0;
    done_at = -1;
    while (busy && cnt < 2000) begin
      led_tr.push_back(int'(led));
      if (done) begin
        n_done++;
        done_at = first_cycle + cnt;
      end
      cnt++;
      step();
    end
    check("capture timeout busy", int'(busy), 0);
  endtask

  // Run lengths of the led trace, starting with a low run.
  task automatic build_runs();
    int lvl, len;
    runs.delete();
    lvl = 0;
    len = 0;
    foreach (led_tr[i]) begin
      if (led_tr[i] == lvl) len++;
      else begin
        runs.push_back(len);
        lvl = led_tr[i];
        len = 1;
      end
    end
    runs.push_back(len);
  endtask

  task automatic check_runs(input string tag);
    build_runs();
    check($sformatf("%s nruns", tag), runs.size(), exp_runs.size());
    foreach (exp_runs[i])
      check($sformatf("%s run%0d", tag, i), (i < runs.size()) ? runs[i] : -1, exp_runs[i]);
  endtask

  initial begin
    int highs;

    // Reset state
    repeat (3) step();
    RESET = 1'b0;
    check("rst led", int'(led), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst full", int'(fifo_full), 0);
    check("rst empty", int'(fifo_empty), 1);
    check("rst overflow", int'(overflow), 0);

    // 1: single E
    push_letter(3'd4);
    check("s1 empty after push", int'(fifo_empty), 0);
    do_start();
    check("s1 busy in LOAD", int'(busy), 1);
    capture(1);
    exp_runs = '{1, 4, 1};
    check_runs("s1");
    check("s1 done cycle", done_at, 6);
    check("s1 done count", n_done, 1);
    check("s1 busy cycles", led_tr.size(), 6);
    check("s1 empty end", int'(fifo_empty), 1);

    // 2: A then E; LOAD adds one low cycle after the 12-cycle letter gap
    push_letter(3'd0);
    push_letter(3'd4);
    do_start();
    capture(1);
    exp_runs = '{1, 4, 4, 12, 13, 4, 1};
    check_runs("s2");
    check("s2 done count", n_done, 1);

    // 3: overflow on DEPTH+1 pushes
    for (int i = 0; i < DEPTH; i++) push_letter(3'd4);
    check("s3 full", int'(fifo_full), 1);
    check("s3 no overflow yet", int'(overflow), 0);
    push_letter(3'd7);
    check("s3 overflow", int'(overflow), 1);
    check("s3 still full", int'(fifo_full), 1);
    do_start();
    check("s3 overflow cleared", int'(overflow), 0);
    capture(1);
    build_runs();
    highs = 0;
    foreach (runs[i]) if (i % 2 == 1) highs++;
    check("s3 marks played", highs, DEPTH);
    check("s3 done count", n_done, 1);

    // 5: push H in the last cycle of A's dash
    push_letter(3'd0);
    do_start();
    repeat (20) step();
    check("s5 dash last cycle led", int'(led), 1);
    letter_in = 3'd7;
    push = 1'b1;
    step();
    push = 1'b0;
    check("s5 gap led", int'(led), 0);
    check("s5 gap busy", int'(busy), 1);
    capture(22);
    exp_runs = '{13, 4, 4, 4, 4, 4, 4, 4, 1};
    check_runs("s5");
    check("s5 done count", n_done, 1);

    // 4: abort mid-dash of B with D queued behind it
    push_letter(3'd1);
    push_letter(3'd3);
    do_start();
    repeat (6) step();
    check("s4 mid dash led", int'(led), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("s4 led after abort", int'(led), 0);
    check("s4 busy after abort", int'(busy), 0);
    check("s4 empty after abort", int'(fifo_empty), 1);
    n_done = 0;
    repeat (20) begin
      if (done) n_done++;
      step();
    end
    check("s4 no done", n_done, 0);
    do_start();
    check("s4 start on empty busy", int'(busy), 0);
    step();
    check("s4 start on empty busy+1", int'(busy), 0);
    check("s4 start on empty done", int'(done), 0);

    // 6: RESET during GAP_SYM of A, D queued
    push_letter(3'd0);
    push_letter(3'd3);
    do_start();
    repeat (5) step();
    check("s6 gap_sym led", int'(led), 0);
    check("s6 gap_sym busy", int'(busy), 1);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check("s6 led", int'(led), 0);
    check("s6 busy", int'(busy), 0);
    check("s6 done", int'(done), 0);
    check("s6 full", int'(fifo_full), 0);
    check("s6 empty", int'(fifo_empty), 1);
    check("s6 overflow", int'(overflow), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
